// File: rtl/hd63701_sci_pkg.sv
// Shared definitions for the HD63701 FIFO-based SCI.
// Covers register offsets, CTRL/STAT bit positions and the receive/transmit engine states.
package hd63701_sci_pkg;

    localparam logic [2:0] OFF_CTRL  = 3'd0;
    localparam logic [2:0] OFF_STAT  = 3'd1;
    localparam logic [2:0] OFF_RDR   = 3'd2;
    localparam logic [2:0] OFF_TDR   = 3'd3;
    localparam logic [2:0] OFF_DIVL  = 3'd4;
    localparam logic [2:0] OFF_DIVH  = 3'd5;
    localparam logic [2:0] OFF_LEVEL = 3'd6;

    localparam int CTRL_TE   = 0;
    localparam int CTRL_RE   = 1;
    localparam int CTRL_TIE  = 2;
    localparam int CTRL_RIE  = 3;
    localparam int CTRL_LOOP = 4;

    localparam int STAT_RXNE    = 0;
    localparam int STAT_RXFULL  = 1;
    localparam int STAT_TXEMPTY = 2;
    localparam int STAT_TXFULL  = 3;
    localparam int STAT_TXIDLE  = 4;
    localparam int STAT_OVR     = 5;
    localparam int STAT_FE      = 6;
    localparam int STAT_TXOVF   = 7;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/hd63701_sync_fifo.sv
// Single-clock FIFO with a power-of-two depth and a head-of-queue output that is always visible.
// Handshake: push is taken when not full, or when a pop of the same cycle frees a slot.
// A pop is taken only when the FIFO is not empty. When both are taken, count is unchanged.
module hd63701_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset: an entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hd63701_sci_fifo.sv
// HD63701 serial interface with configurable frame width, 16-bit divisor, RX/TX FIFOs and loopback.
// Occupies an 8-byte window on the internal MCU bus and drives IRQ0 with a level interrupt.
module hd63701_sci_fifo
    import hd63701_sci_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'h0010,
    parameter int          DATA_BITS = 8,
    parameter int          RX_DEPTH  = 4,
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd255
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst_n,
    input  logic [15:0] mcu_ad,
    input  logic        mcu_wr,
    input  logic        mcu_rd,
    input  logic [7:0]  mcu_do,
    output logic        en_sci,
    output logic [7:0]  iod,
    input  logic        rx,
    output logic        tx,
    output logic        te,
    output logic        mcu_irq0
);

    localparam int RCW = $clog2(RX_DEPTH + 1);
    localparam int TCW = $clog2(TX_DEPTH + 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Bus decode and register file
    logic [15:0] off_full;
    logic [2:0]  off;
    logic        wr_hit;
    logic        wr_stat;
    logic        tdr_wr;
    logic        rdr_rd;
    logic [4:0]  ctrl;
    logic [15:0] div;
    logic        ovr;
    logic        fe;
    logic        txovf;
    logic        ovr_set;
    logic        fe_set;
    logic        txovf_set;
    logic [7:0]  stat;

    assign off_full = mcu_ad - BASE;
    assign en_sci   = (off_full[15:3] == 13'd0);
    assign off      = off_full[2:0];
    assign wr_hit   = mcu_wr & en_sci;
    assign wr_stat  = wr_hit & (off == OFF_STAT);
    assign tdr_wr   = wr_hit & (off == OFF_TDR);
    assign rdr_rd   = mcu_rd & en_sci & (off == OFF_RDR);
    assign te       = ctrl[CTRL_TE];

    // FIFOs
    logic                 rx_push;
    logic                 rx_full;
    logic                 rx_empty;
    logic [RCW-1:0]       rx_count;
    logic [DATA_BITS-1:0] rx_head;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 tx_pop;
    logic                 tx_full;
    logic                 tx_empty;
    logic [TCW-1:0]       tx_count;
    logic [DATA_BITS-1:0] tx_head;

    hd63701_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (mcu_clx2),
        .rst_n (mcu_rst_n),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rdr_rd),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .head  (rx_head)
    );

    hd63701_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (mcu_clx2),
        .rst_n (mcu_rst_n),
        .push  (tdr_wr),
        .wdata (mcu_do[DATA_BITS-1:0]),
        .pop   (tx_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (tx_head)
    );

    // A full RX FIFO drained in the same cycle still has room, so that case is not an overrun.
    assign ovr_set   = rx_push & rx_full & ~rdr_rd;
    assign txovf_set = tdr_wr & tx_full & ~tx_pop;

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            ctrl  <= '0;
            div   <= DIV_RESET;
            ovr   <= 1'b0;
            fe    <= 1'b0;
            txovf <= 1'b0;
        end else begin
            if (wr_hit) begin
                case (off)
                    OFF_CTRL: ctrl       <= mcu_do[4:0];
                    OFF_DIVL: div[7:0]   <= mcu_do;
                    OFF_DIVH: div[15:8]  <= mcu_do;
                    default:  ctrl       <= ctrl;
                endcase
            end
            // A hardware set in the same cycle as a write-1-to-clear leaves the flag set.
            ovr   <= ovr_set   | (ovr   & ~(wr_stat & mcu_do[STAT_OVR]));
            fe    <= fe_set    | (fe    & ~(wr_stat & mcu_do[STAT_FE]));
            txovf <= txovf_set | (txovf & ~(wr_stat & mcu_do[STAT_TXOVF]));
        end
    end

    // Receiver
    rx_state_t   rx_state;
    rx_state_t   rx_state_d;
    logic [1:0]  rx_sync;
    logic        rx_prev;
    logic        rx_i;
    logic        rx_fall;
    logic [15:0] rx_cnt;
    logic [15:0] rx_div;
    logic [2:0]  rx_bit;
    logic        rx_tick;
    logic        rx_half;

    // Loopback taps the shifter output directly, so it skips the synchroniser.
    assign rx_i    = ctrl[CTRL_LOOP] ? tx : rx_sync[1];
    assign rx_fall = rx_prev & ~rx_i;
    assign rx_tick = (rx_cnt == rx_div);
    assign rx_half = (rx_cnt == (rx_div >> 1));

    always_comb begin
        rx_state_d = rx_state;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        if (!ctrl[CTRL_RE]) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
                RX_START: if (rx_half) rx_state_d = rx_i ? RX_IDLE : RX_DATA;
                RX_DATA:  if (rx_tick && rx_bit == LAST_BIT) rx_state_d = RX_STOP;
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_state_d = RX_IDLE;
                        rx_push    = rx_i;
                        fe_set     = ~rx_i;
                    end
                end
                default:  rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            rx_state <= RX_IDLE;
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_sync  <= {rx_sync[0], rx};
            rx_prev  <= rx_i;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    // The divisor is frozen for the whole frame from the start edge on.
                    if (rx_fall) rx_div <= div;
                end
                RX_START: rx_cnt <= rx_half ? 16'd0 : rx_cnt + 16'd1;
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_bit   <= rx_bit + 3'd1;
                        rx_shift <= {rx_i, rx_shift[DATA_BITS-1:1]};
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_cnt <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
            endcase
        end
    end

    // Transmitter
    tx_state_t            tx_state;
    tx_state_t            tx_state_d;
    logic [15:0]          tx_cnt;
    logic [15:0]          tx_div;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_tick;
    logic                 tx_go;

    assign tx_tick = (tx_cnt == tx_div);
    assign tx_go   = ctrl[CTRL_TE] & ~tx_empty;
    assign tx      = (tx_state == TX_START) ? 1'b0 :
                     (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    // TE is only consulted at frame boundaries, so a running frame always completes.
    always_comb begin
        tx_state_d = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_go) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_tick) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == LAST_BIT) tx_state_d = TX_STOP;
            TX_STOP: begin
                if (tx_tick) begin
                    tx_pop     = tx_go;
                    tx_state_d = tx_go ? TX_START : TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_d;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_div   <= div;
                tx_cnt   <= '0;
            end else begin
                case (tx_state)
                    TX_START: begin
                        tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
                        if (tx_tick) tx_bit <= '0;
                    end
                    TX_DATA: begin
                        if (tx_tick) begin
                            tx_cnt   <= '0;
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                        end else begin
                            tx_cnt <= tx_cnt + 16'd1;
                        end
                    end
                    TX_STOP: tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
                    default: tx_cnt <= '0;
                endcase
            end
        end
    end

    // Status, read mux and interrupt
    assign stat = {txovf, fe, ovr, tx_empty & (tx_state == TX_IDLE),
                   tx_full, tx_empty, rx_full, ~rx_empty};

    always_comb begin
        iod = '0;
        if (en_sci) begin
            case (off)
                OFF_CTRL:  iod = {3'b000, ctrl};
                OFF_STAT:  iod = stat;
                OFF_RDR:   iod = rx_empty ? 8'h00 : 8'(rx_head);
                OFF_DIVL:  iod = div[7:0];
                OFF_DIVH:  iod = div[15:8];
                OFF_LEVEL: iod = {4'(rx_count), 4'(tx_count)};
                default:   iod = '0;
            endcase
        end
    end

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            mcu_irq0 <= 1'b0;
        end else begin
            mcu_irq0 <= (ctrl[CTRL_RIE] & (~rx_empty | ovr | fe)) |
                        (ctrl[CTRL_TIE] & tx_empty);
        end
    end

endmodule

// File: tb/tb_hd63701_sci_fifo.sv
// Bench for hd63701_sci_fifo: an 8-bit instance at 0x0010 and a 7-bit instance at 0x0020 share the bus.
// Bus reads and decoded TX frames are matched against expectations queued by the directed stimulus.
`timescale 1ns/1ps
module tb_hd63701_sci_fifo;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mcu_ad = '0;
    logic        mcu_wr = 1'b0;
    logic        mcu_rd = 1'b0;
    logic [7:0]  mcu_do = '0;
    logic        rx = 1'b1;
    logic        en_sci, tx, te, irq;
    logic        en7, tx7, te7, irq7;
    logic [7:0]  iod, iod7, iod_bus;

    hd63701_sci_fifo #(.BASE(16'h0010)) u_dut (
        .mcu_clx2 (clk),    .mcu_rst_n (rst_n), .mcu_ad (mcu_ad), .mcu_wr (mcu_wr),
        .mcu_rd   (mcu_rd), .mcu_do    (mcu_do), .en_sci (en_sci), .iod    (iod),
        .rx       (rx),     .tx        (tx),     .te     (te),     .mcu_irq0 (irq)
    );

    hd63701_sci_fifo #(.BASE(16'h0020), .DATA_BITS(7)) u_dut7 (
        .mcu_clx2 (clk),    .mcu_rst_n (rst_n), .mcu_ad (mcu_ad), .mcu_wr (mcu_wr),
        .mcu_rd   (mcu_rd), .mcu_do    (mcu_do), .en_sci (en7),   .iod    (iod7),
        .rx       (1'b1),   .tx        (tx7),    .te     (te7),   .mcu_irq0 (irq7)
    );

    assign iod_bus = en7 ? iod7 : iod;

    // Scoreboard state
    int          n_checks = 0;
    int          n_fail = 0;
    int          bit_clks = 4;
    bit          mon_en = 1'b1;
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rd_exp_q[$];
    string       rd_name_q[$];
    event        rd_ev;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        mcu_ad = a; mcu_do = d; mcu_wr = 1'b1;
        @(negedge clk);
        mcu_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        mcu_ad = a; mcu_rd = 1'b1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        #2 -> rd_ev;
        @(negedge clk);
        mcu_rd = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop, input int clks);
        @(negedge clk);
        rx = 1'b0;
        repeat (clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (clks) @(negedge clk);
        end
        rx = stop;
        repeat (clks) @(negedge clk);
        rx = 1'b1;
    endtask

    // Read monitor: compares read data while the strobe is held, away from the clock edge
    initial begin : rd_mon
        logic [7:0] e;
        string      nm;
        forever begin
            @(rd_ev);
            if (rd_exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_unexpected: got %02h expected no read", iod_bus);
            end else begin
                e  = rd_exp_q.pop_front();
                nm = rd_name_q.pop_front();
                chk(nm, iod_bus, e);
            end
        end
    end

    // TX monitor: decodes 8-bit frames on the main instance's tx line at mid-bit
    initial begin : tx_mon
        logic       prev;
        logic [7:0] got;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx && mon_en) begin
                repeat (bit_clks / 2) @(negedge clk);
                chk("tx_start_bit", {7'b0, tx}, 8'h00);
                got = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (bit_clks) @(negedge clk);
                    got[i] = tx;
                end
                repeat (bit_clks) @(negedge clk);
                chk("tx_stop_bit", {7'b0, tx}, 8'h01);
                if (tx_exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_unexpected_frame: got %02h expected none", got);
                end else begin
                    chk("tx_frame", got, tx_exp_q.pop_front());
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        n_checks++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    logic [7:0] ovr_frames [5];

    initial begin
        ovr_frames = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {7'b0, tx}, 8'h01);
        chk("rst_te", {7'b0, te}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        rst_n = 1'b1;
        bus_rd(16'h0011, 8'h14, "rst_stat");
        bus_rd(16'h0010, 8'h00, "rst_ctrl");
        bus_rd(16'h0014, 8'hFF, "rst_divl");
        bus_rd(16'h0015, 8'h00, "rst_divh");
        bus_rd(16'h0016, 8'h00, "rst_level");
        bus_rd(16'h0017, 8'h00, "rsvd_reg");
        @(negedge clk); mcu_ad = 16'h0017; #1;
        chk("en_last", {7'b0, en_sci}, 8'h01);
        mcu_ad = 16'h0018; #1;
        chk("en_above", {7'b0, en_sci}, 8'h00);
        mcu_ad = 16'h000F; #1;
        chk("en_below", {7'b0, en_sci}, 8'h00);

        // Loopback frame A5 at DIV=3
        bus_wr(16'h0014, 8'h03);
        bus_wr(16'h0010, 8'h13);
        bit_clks = 4;
        tx_exp_q.push_back(8'hA5);
        bus_wr(16'h0013, 8'hA5);
        repeat (50) @(negedge clk);
        bus_rd(16'h0011, 8'h15, "loop_stat_rxne");
        bus_rd(16'h0012, 8'hA5, "loop_rdr");
        bus_rd(16'h0011, 8'h14, "loop_stat_after");

        // TX FIFO fill with TE=0, overflow, then contiguous drain
        bus_wr(16'h0010, 8'h00);
        for (int i = 1; i <= 5; i++) bus_wr(16'h0013, 8'(i));
        bus_rd(16'h0011, 8'h88, "txfull_stat");
        bus_rd(16'h0016, 8'h04, "txfull_level");
        for (int i = 1; i <= 4; i++) tx_exp_q.push_back(8'(i));
        bus_wr(16'h0010, 8'h01);
        repeat (161) @(negedge clk);
        bus_rd(16'h0011, 8'h94, "drain_stat");
        bus_wr(16'h0011, 8'h80);
        bus_rd(16'h0011, 8'h14, "txovf_clr");

        // Framing error at DIV=7, then a short glitch
        bus_wr(16'h0014, 8'h07);
        bus_wr(16'h0010, 8'h02);
        send_rx(8'h3C, 1'b0, 8);
        repeat (6) @(negedge clk);
        bus_rd(16'h0011, 8'h54, "fe_stat");
        bus_rd(16'h0016, 8'h00, "fe_level");
        bus_wr(16'h0011, 8'h40);
        bus_rd(16'h0011, 8'h14, "fe_clr");
        @(negedge clk); rx = 1'b0;
        repeat (2) @(negedge clk); rx = 1'b1;
        repeat (30) @(negedge clk);
        bus_rd(16'h0011, 8'h14, "glitch_stat");

        // RX overrun with RIE
        bus_wr(16'h0010, 8'h0A);
        for (int i = 0; i < 5; i++) send_rx(ovr_frames[i], 1'b1, 8);
        repeat (4) @(negedge clk);
        chk("ovr_irq", {7'b0, irq}, 8'h01);
        bus_rd(16'h0011, 8'h37, "ovr_stat");
        bus_rd(16'h0016, 8'h40, "ovr_level");
        for (int i = 0; i < 4; i++) bus_rd(16'h0012, ovr_frames[i], "ovr_rdr");
        bus_rd(16'h0012, 8'h00, "rdr_empty");
        bus_rd(16'h0011, 8'h34, "ovr_sticky");
        bus_wr(16'h0011, 8'h20);
        bus_rd(16'h0011, 8'h14, "ovr_clr");
        chk("irq_cleared", {7'b0, irq}, 8'h00);

        // RE cleared mid-frame, then a clean frame
        bus_wr(16'h0010, 8'h02);
        fork
            send_rx(8'h5A, 1'b1, 8);
            begin
                repeat (30) @(negedge clk);
                bus_wr(16'h0010, 8'h00);
            end
        join
        repeat (10) @(negedge clk);
        bus_rd(16'h0011, 8'h14, "abort_stat");
        bus_rd(16'h0016, 8'h00, "abort_level");
        bus_wr(16'h0010, 8'h02);
        send_rx(8'h96, 1'b1, 8);
        repeat (4) @(negedge clk);
        bus_rd(16'h0012, 8'h96, "after_abort_rdr");

        // Asynchronous reset in the middle of a TX frame
        bus_wr(16'h0014, 8'h03);
        bus_wr(16'h0010, 8'h01);
        mon_en = 1'b0;
        bus_wr(16'h0013, 8'hC3);
        repeat (15) @(negedge clk);
        #2;
        chk("tx_pre_rst", {7'b0, tx}, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("tx_async_rst", {7'b0, tx}, 8'h01);
        chk("te_async_rst", {7'b0, te}, 8'h00);
        bus_rd(16'h0011, 8'h14, "rst_mid_stat");
        bus_rd(16'h0014, 8'hFF, "rst_mid_divl");
        bus_rd(16'h0015, 8'h00, "rst_mid_divh");
        @(negedge clk); rst_n = 1'b1;
        mon_en = 1'b1;

        // 7-bit instance: loopback of FF, then TX-empty interrupt
        bus_wr(16'h0024, 8'h03);
        bus_wr(16'h0020, 8'h13);
        bus_wr(16'h0023, 8'hFF);
        repeat (45) @(negedge clk);
        bus_rd(16'h0022, 8'h7F, "db7_rdr");
        bus_rd(16'h0021, 8'h14, "db7_stat");
        chk("db7_irq_off", {7'b0, irq7}, 8'h00);
        bus_wr(16'h0020, 8'h17);
        chk("db7_irq_latency", {7'b0, irq7}, 8'h00);
        @(negedge clk);
        chk("db7_irq_tie", {7'b0, irq7}, 8'h01);

        // Drain and report
        repeat (20) @(negedge clk);
        chk("tx_q_drained", 8'(tx_exp_q.size()), 8'h00);
        chk("rd_q_drained", 8'(rd_exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
